// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: time-multiplexes NUM_DIGITS hex digits onto a shared
// 8-bit segment bus {a,b,c,d,e,f,g,dp}. All display inputs are captured into
// shadow registers once per frame, so a frame never mixes old and new values.
// Each digit slot starts with DEAD_CYCLES of darkness to avoid ghosting.
// Optional build macro SSEG_BRIGHTNESS_EN adds a 4-bit brightness_i port that
// shortens the lit part of every slot.
module seven_segment_scanner #(
  parameter int NUM_DIGITS       = 8,
  parameter int DIGIT_CYCLES     = 50000,
  parameter int DEAD_CYCLES      = 500,
  parameter int DIGIT_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW   = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_DIGITS*4-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic                    lzs_en_i,
`ifdef SSEG_BRIGHTNESS_EN
  input  logic [3:0]              brightness_i,
`endif
  output logic [NUM_DIGITS-1:0]   digit_en_o,
  output logic [7:0]              seg_o,
  output logic                    frame_o
);

  localparam int TICK_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIGIT_CYCLES - 1);
  localparam logic [TICK_W-1:0] DEAD_T    = TICK_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Inactive levels; XOR with these applies the board polarity as the last step.
  localparam logic [NUM_DIGITS-1:0] DIGIT_OFF =
      (DIGIT_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  // Slot timing counters and frame control
  logic [TICK_W-1:0] tick_reg, tick_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic              load_pending_reg;
  logic              capture;
  logic              frame_reg;

  // Shadow copies of the display inputs, refreshed only at frame start
  logic [NUM_DIGITS*4-1:0] value_shadow_reg;
  logic [NUM_DIGITS-1:0]   dp_shadow_reg;
  logic [NUM_DIGITS-1:0]   blank_shadow_reg;
  logic                    lzs_shadow_reg;

  // Per-digit decode results (active-high) and the slot decision
  logic [7:0]            pattern   [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] zero_like;
  logic [NUM_DIGITS-1:0] suppress;
  logic [NUM_DIGITS-1:0] digit_onehot;
  logic [7:0]            pattern_sel;
  logic                  driven;
  logic                  lit;

  // Registered pin drivers
  logic [NUM_DIGITS-1:0] digit_en_reg, digit_en_next;
  logic [7:0]            seg_reg, seg_next;

  // Hex to active-high abcdefg
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  // Next-state of the scan counters; the first edge after reset is a frame
  // start that holds the counters at slot 0 so every frame_o lines up with
  // tick 0 of digit 0.
  always_comb begin
    tick_next = tick_reg;
    idx_next  = idx_reg;
    capture   = 1'b0;
    if (load_pending_reg) begin
      capture = 1'b1;
    end else if (tick_reg == TICK_LAST) begin
      tick_next = '0;
      if (idx_reg == IDX_LAST) begin
        idx_next = '0;
        capture  = 1'b1;
      end else begin
        idx_next = idx_reg + 1'b1;
      end
    end else begin
      tick_next = tick_reg + 1'b1;
    end
  end

  // Scan counters, pending-load flag and the frame pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_reg         <= '0;
      idx_reg          <= '0;
      load_pending_reg <= 1'b1;
      frame_reg        <= 1'b0;
    end else begin
      tick_reg         <= tick_next;
      idx_reg          <= idx_next;
      load_pending_reg <= 1'b0;
      frame_reg        <= capture;
    end
  end

  // Shadow capture of the display inputs at frame start
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_shadow_reg <= '0;
      dp_shadow_reg    <= '0;
      blank_shadow_reg <= '0;
      lzs_shadow_reg   <= 1'b0;
    end else if (capture) begin
      value_shadow_reg <= value_i;
      dp_shadow_reg    <= dp_i;
      blank_shadow_reg <= blank_i;
      lzs_shadow_reg   <= lzs_en_i;
    end
  end

  // A digit "looks zero" for suppression if its nibble is zero or it is
  // blanked; suppression runs down from the top digit while that holds and
  // never reaches digit 0.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] nib;
      assign nib           = value_shadow_reg[4*gi +: 4];
      assign zero_like[gi] = (nib == 4'h0) | blank_shadow_reg[gi];

      if (gi == 0) begin : g_lsd
        assign suppress[gi] = 1'b0;
      end else if (gi == NUM_DIGITS - 1) begin : g_msd
        assign suppress[gi] = lzs_shadow_reg & zero_like[gi];
      end else begin : g_mid
        assign suppress[gi] = suppress[gi+1] & zero_like[gi];
      end

      // Blank wins over everything, the dp survives suppression
      assign pattern[gi] = blank_shadow_reg[gi] ? 8'h00 :
                           {(suppress[gi] ? 7'b0000000 : hex_to_seg(nib)),
                            dp_shadow_reg[gi]};

      assign digit_onehot[gi] = lit & (idx_reg == IDX_W'(gi));
    end
  endgenerate

  // Select the pattern of the digit owning the current slot
  always_comb begin
    pattern_sel = 8'h00;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_reg == IDX_W'(k)) begin
        pattern_sel = pattern[k];
      end
    end
  end

  assign driven = !load_pending_reg && (tick_reg >= DEAD_T);

`ifdef SSEG_BRIGHTNESS_EN
  localparam int PROD_W   = TICK_W + 5;
  localparam int L_CYCLES = DIGIT_CYCLES - DEAD_CYCLES;

  logic [3:0]        brightness_shadow_reg;
  logic [PROD_W-1:0] on_limit;
  logic [PROD_W-1:0] phase;

  // Brightness is part of the frame snapshot like the other inputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      brightness_shadow_reg <= 4'h0;
    end else if (capture) begin
      brightness_shadow_reg <= brightness_i;
    end
  end

  // Lit only for the first ((brightness+1)*L)/16 cycles of the driven phase
  always_comb begin
    on_limit = ((PROD_W'(brightness_shadow_reg) + PROD_W'(1)) *
                PROD_W'(L_CYCLES)) >> 4;
    phase    = PROD_W'(tick_reg - DEAD_T);
    lit      = driven && (phase < on_limit);
  end
`else
  assign lit = driven;
`endif

  assign digit_en_next = digit_onehot ^ DIGIT_OFF;
  assign seg_next      = (lit ? pattern_sel : 8'h00) ^ SEG_OFF;

  // Registered pin drivers; reset forces everything dark immediately
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      digit_en_reg <= DIGIT_OFF;
      seg_reg      <= SEG_OFF;
    end else begin
      digit_en_reg <= digit_en_next;
      seg_reg      <= seg_next;
    end
  end

  assign digit_en_o = digit_en_reg;
  assign seg_o      = seg_reg;
  assign frame_o    = frame_reg;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner with 4 digits, 8-cycle slots, 2 dead cycles,
// active-low digits and segments. A frame-level reference model predicts the
// pins from the edge count since reset release and the frame snapshot.
module tb_seven_segment_scanner;

  localparam int N     = 4;
  localparam int DC    = 8;
  localparam int DEAD  = 2;
  localparam int FRAME = N * DC;
  localparam int L     = DC - DEAD;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [15:0]   value_i = 16'h0000;
  logic [3:0]    dp_i = 4'h0;
  logic [3:0]    blank_i = 4'h0;
  logic          lzs_en_i = 1'b0;
`ifdef SSEG_BRIGHTNESS_EN
  logic [3:0]    brightness_i = 4'hF;
`endif
  logic [3:0]    digit_en_o;
  logic [7:0]    seg_o;
  logic          frame_o;

  seven_segment_scanner #(
    .NUM_DIGITS(N), .DIGIT_CYCLES(DC), .DEAD_CYCLES(DEAD),
    .DIGIT_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .value_i(value_i), .dp_i(dp_i), .blank_i(blank_i), .lzs_en_i(lzs_en_i),
`ifdef SSEG_BRIGHTNESS_EN
    .brightness_i(brightness_i),
`endif
    .digit_en_o(digit_en_o), .seg_o(seg_o), .frame_o(frame_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Active-high abcdefg per hex digit
  logic [6:0] dec [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  // Reference model state: edges since release and the frame snapshot
  int         k = 0;
  int         frames = 0;
  logic [15:0] sh_value = '0;
  logic [3:0]  sh_dp = '0, sh_blank = '0;
  logic        sh_lzs = 1'b0;
  int          sh_bright = 15;
  logic [3:0]  exp_en;
  logic [7:0]  exp_seg;
  logic        exp_frame;

  // Lit segments (active high) for digit i under the current snapshot
  function automatic logic [7:0] lit_segments(input int i);
    bit zero_run = 1'b1;
    logic [3:0] nib;
    logic [6:0] s;
    for (int j = N - 1; j >= i; j--) begin
      if (sh_value[4*j +: 4] != 4'h0 && !sh_blank[j]) zero_run = 1'b0;
    end
    if (sh_blank[i]) return 8'h00;
    nib = sh_value[4*i +: 4];
    s = (sh_lzs && i != 0 && zero_run) ? 7'b0 : dec[nib];
    return {s, sh_dp[i]};
  endfunction

  // One clock: predict pins from the pre-edge view, update snapshot, compare
  task automatic step();
    int p, i, t;
    bit on;
    logic [3:0] sel;
    @(posedge clk_i);
    k++;
    exp_frame = ((k - 1) % FRAME == 0);
    if (k == 1) begin
      exp_en  = 4'hF;
      exp_seg = 8'hFF;
    end else begin
      p  = (k - 2) % FRAME;
      i  = p / DC;
      t  = p % DC;
      on = (t >= DEAD);
`ifdef SSEG_BRIGHTNESS_EN
      on = on && ((t - DEAD) < ((sh_bright + 1) * L) / 16);
`endif
      sel     = 4'b0001 << i;
      exp_en  = on ? ~sel : 4'hF;
      exp_seg = on ? ~lit_segments(i) : 8'hFF;
    end
    if (exp_frame) begin
      sh_value = value_i;
      sh_dp    = dp_i;
      sh_blank = blank_i;
      sh_lzs   = lzs_en_i;
`ifdef SSEG_BRIGHTNESS_EN
      sh_bright = int'(brightness_i);
`endif
      frames++;
      $display("frame %0d: value=%h dp=%b blank=%b lzs=%b bright=%0d (checks=%0d errors=%0d)",
               frames, value_i, dp_i, blank_i, lzs_en_i, sh_bright, checks, errors);
    end
    #1;
    check("digit_en", digit_en_o, exp_en);
    check("seg", seg_o, exp_seg);
    check("frame", frame_o, exp_frame);
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) step();
  endtask

  task automatic check_in_reset(input string tag);
    check({tag, "_digit_en"}, digit_en_o, 4'hF);
    check({tag, "_seg"}, seg_o, 8'hFF);
    check({tag, "_frame"}, frame_o, 1'b0);
  endtask

  // Release at a falling edge so the next rising edge is the first frame start
  task automatic release_reset();
    @(negedge clk_i);
    rst_ni   = 1'b1;
    k        = 0;
    sh_value = '0;
    sh_dp    = '0;
    sh_blank = '0;
    sh_lzs   = 1'b0;
    sh_bright = 0;
  endtask

  task automatic set_inputs(input logic [15:0] v, input logic [3:0] dp,
                            input logic [3:0] bl, input logic lzs);
    value_i  = v;
    dp_i     = dp;
    blank_i  = bl;
    lzs_en_i = lzs;
  endtask

  initial begin
    int guard;
    // Held in reset: all outputs dark, no frame pulse
    repeat (3) @(posedge clk_i);
    #1 check_in_reset("reset_hold");
    release_reset();
    run(2 * FRAME + 4);

    set_inputs(16'h1A8F, 4'h0, 4'h0, 1'b0);
    run(2 * FRAME);

    set_inputs(16'h0050, 4'b1000, 4'h0, 1'b1);
    run(2 * FRAME);
    set_inputs(16'h0000, 4'h0, 4'h0, 1'b1);
    run(2 * FRAME);

    // Mid-frame change must not tear: switch at digit 2, tick 4
    set_inputs(16'h1111, 4'h0, 4'h0, 1'b0);
    run(FRAME);
    guard = 0;
    while (((k - 1) % FRAME) != 2 * DC + 4 && guard < 2 * FRAME) begin
      step();
      guard++;
    end
    check("mid_frame_sync", (guard < 2 * FRAME), 1'b1);
    value_i = 16'h2222;
    run(2 * FRAME);

    // Blanked digit keeps its enable but shows nothing, not even the dp
    set_inputs(16'h1234, 4'b0010, 4'b0010, 1'b0);
    run(2 * FRAME);

    // Reset during the lit part of a slot goes dark without a clock edge
    guard = 0;
    while (exp_en == 4'hF && guard < FRAME) begin
      step();
      guard++;
    end
    check("lit_before_reset", (exp_en != 4'hF), 1'b1);
    #2 rst_ni = 1'b0;
    #1 check_in_reset("async_reset");
    repeat (2) @(posedge clk_i);
    #1 check_in_reset("reset_again");
    release_reset();
    run(2 * FRAME);

    // Randomized traffic, including changes at arbitrary points of a frame
    for (int c = 0; c < 40 * FRAME; c++) begin
      if ($urandom_range(7, 0) == 0) begin
        for (int j = 0; j < N; j++) begin
          value_i[4*j +: 4] = ($urandom_range(1, 0) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
        end
        dp_i     = 4'($urandom_range(15, 0));
        blank_i  = ($urandom_range(3, 0) == 0) ? 4'($urandom_range(15, 0)) : 4'h0;
        lzs_en_i = 1'($urandom_range(1, 0));
`ifdef SSEG_BRIGHTNESS_EN
        brightness_i = 4'($urandom_range(15, 0));
`endif
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
- Parametrised successor to the team's multiplexed seven-segment driver. It time-multiplexes NUM_DIGITS hex digits onto a shared segment bus.
- New over the previous generation: async active-low reset, frame-synchronous shadow capture (no tearing), per-digit blanking and decimal points, leading-zero suppression, anti-ghosting dead time, and configurable output polarity.
- Sits between the register/debug logic producing value_i and the board's digit/segment pins.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digits; legal range >= 2, non-power-of-2 allowed.
- DIGIT_CYCLES, 50000, clock cycles per digit slot (1 ms at 50 MHz); must exceed DEAD_CYCLES + 1.
- DEAD_CYCLES, 500, cycles at the start of each slot with all digits off (anti-ghosting); 0 is legal.
- DIGIT_ACTIVE_LOW, 1, 1 means digit enables are driven low when active.
- SEG_ACTIVE_LOW, 1, 1 means segments are driven low when lit.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- value_i  input  NUM_DIGITS*4  hex nibbles; digit k = value_i[4k+3:4k]; digit 0 is least significant (rightmost)
- dp_i  input  NUM_DIGITS  per-digit decimal point request
- blank_i  input  NUM_DIGITS  per-digit forced blank; also blanks the dp
- lzs_en_i  input  1  leading-zero suppression enable
- digit_en_o  output  NUM_DIGITS  one-hot (polarity per DIGIT_ACTIVE_LOW) digit select
- seg_o  output  8  {a,b,c,d,e,f,g,dp}, bit 7 = a, bit 0 = dp (polarity per SEG_ACTIVE_LOW)
- frame_o  output  1  one-cycle pulse when a new frame starts (shadow captured)

Behaviour:
- Clock and reset: one clock (clk_i). Reset is asynchronous assert, synchronous deassert, active-low on rst_ni.
- Counters: tick counts 0..DIGIT_CYCLES-1. When tick wraps, idx advances 0..NUM_DIGITS-1 and wraps to 0.
- Reset state:
  - tick = 0, idx = 0, shadow registers = 0, load_pending = 1.
  - digit_en_o = all inactive; seg_o = all inactive (0xFF when SEG_ACTIVE_LOW = 1); frame_o = 0.
- Shadow capture: on the clock edge entering tick 0 of idx 0, value_i, dp_i, blank_i and lzs_en_i are captured into shadow registers.
  - The first edge after reset deassertion counts as a frame start; load_pending is cleared there.
  - frame_o is high for exactly the cycle after the capture edge.
  - Input changes mid-frame have no visible effect until the next frame.
- Display slot:
  - For tick < DEAD_CYCLES, all digits are inactive and segments are inactive.
  - Otherwise, digit idx is active and seg_o shows its decoded pattern.
- Latency: digit_en_o and seg_o are registered and lag (idx, tick) by exactly one cycle. No combinational path from inputs to outputs.
- Decode: standard hex 0-F, active-high abcdefg.
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
  - dp bit = shadow dp. Polarity inversion is applied last.
- Leading-zero suppression (shadow lzs_en = 1):
  - Scanning from digit NUM_DIGITS-1 downward, every digit whose nibble is 0 and all of whose more-significant digits are also suppressed has its abcdefg blanked. The scan stops at the first nonzero nibble.
  - Digit 0 is never suppressed; an all-zero value displays as a single "0".
  - dp on a suppressed digit is still shown.
  - A blank_i'd digit does not count as nonzero, so it does not stop suppression.
- Blank: a shadow blank bit forces all 8 segments inactive for that digit; its digit enable is still asserted (timing unchanged).
- Reset mid-operation: outputs go inactive immediately (asynchronously). The scan restarts at idx 0 with a fresh capture on the first edge after release.

Optional Feature:
- Macro: SSEG_BRIGHTNESS_EN.
- Defined:
  - Adds port brightness_i (input, 4 bits), captured into shadow at frame start like the other inputs.
  - Within the driven part of a slot, let p = tick - DEAD_CYCLES and L = DIGIT_CYCLES - DEAD_CYCLES.
  - The digit is active only while p < ((brightness+1)*L) >> 4; the rest of the slot is dark (digit and segments inactive).
  - brightness = 15 gives full on-time; brightness = 0 gives L/16 cycles.
- Undefined: the port is absent and the digit is on for the full driven phase, identical to brightness = 15.

Test Plan:
- Test parameters: NUM_DIGITS=4, DIGIT_CYCLES=8, DEAD_CYCLES=2, both polarities active-low.
- Scenarios:
  - Reset, value_i=16'h0000, lzs_en_i=0, dp_i=0, blank_i=0 -> while held in reset: digit_en_o=4'hF, seg_o=8'hFF. After release: frame_o pulses once; each 8-cycle slot shows 2 cycles dark, then 6 cycles of digit_en_o=~(1<<idx) with seg_o=8'h03 ("0").
  - value_i=16'h1A8F -> digit0 seg_o=8'h71 (F), digit1 8'h01 (8), digit2 8'h11 (A), digit3 8'h9F (1); frame_o every 32 cycles.
  - value_i=16'h0050, lzs_en_i=1, dp_i=4'b1000 -> digit3 seg_o=8'hFE (dp only), digit2 8'hFF, digit1 8'h49 (5), digit0 8'h03. With value_i=0: only digit0 shows 8'h03.
  - Change value_i from 16'h1111 to 16'h2222 at idx=2, tick=4 -> digits 2 and 3 still show 8'h9F; new value appears only after the next frame_o.
  - blank_i=4'b0010 with dp_i=4'b0010 -> digit1 slot shows digit_en_o=4'hD with seg_o=8'hFF. Assert rst_ni=0 mid-slot -> outputs inactive in the same cycle; scan restarts at idx 0.
  - With SSEG_BRIGHTNESS_EN defined, brightness_i=7 -> L=6, on-time=(8*6)>>4=3 cycles per slot. brightness_i=15 -> 6 cycles.
